// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// WORD_SIZE is the MSB index of a register word, so data buses are WORD_SIZE+1 bits.
package rf_wb_scheduler_pkg;

   localparam int WORD_SIZE = 31;
   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [WORD_SIZE:0]   word_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ALU  = 2'd1,
      GNT_LSU  = 2'd2
   } grant_e;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Writeback bus: ALU and LSU request handshakes plus the register file write port.
interface rf_wb_scheduler_if;
   import rf_wb_scheduler_pkg::*;

   logic     i_alu_valid;
   reg_idx_t i_alu_rd;
   word_t    i_alu_wd;
   logic     o_alu_ready;

   logic     i_lsu_valid;
   reg_idx_t i_lsu_rd;
   word_t    i_lsu_wd;
   logic     o_lsu_ready;

   logic     o_Wen;
   reg_idx_t o_Wnum;
   word_t    o_Wd;

   // Requesters and register file side
   modport master (
      output i_alu_valid, i_alu_rd, i_alu_wd,
      output i_lsu_valid, i_lsu_rd, i_lsu_wd,
      input  o_alu_ready, o_lsu_ready,
      input  o_Wen, o_Wnum, o_Wd
   );

   // Scheduler side
   modport slave (
      input  i_alu_valid, i_alu_rd, i_alu_wd,
      input  i_lsu_valid, i_lsu_rd, i_lsu_wd,
      output o_alu_ready, o_lsu_ready,
      output o_Wen, o_Wnum, o_Wd
   );

endinterface

// File: rtl/rf_wb_scheduler_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, with the decode hazard compare.
module rf_scoreboard
   import rf_wb_scheduler_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_issue_en,
   input  reg_idx_t            i_issue_rd,
   input  reg_idx_t            i_rs1,
   input  reg_idx_t            i_rs2,
   input  logic                i_clr_en,
   input  reg_idx_t            i_clr_rd,
   output logic                o_stall,
   output logic [NUM_REGS-1:0] o_busy
);

   logic [NUM_REGS-1:0] busy_d, busy_q;
   logic                hazard;

   // Hazard compare against the registered busy bits; a write landing this
   // cycle still counts as pending because the register file returns old data.
   always_comb begin
      hazard = 1'b0;
      if ((i_rs1 != '0) && busy_q[i_rs1]) hazard = 1'b1;
      if ((i_rs2 != '0) && busy_q[i_rs2]) hazard = 1'b1;
      if (i_issue_en && (i_issue_rd != '0) && busy_q[i_issue_rd]) hazard = 1'b1;
      o_stall = i_rst_n && hazard;
   end

   // Next busy vector: clear first so a same-register issue overrides it;
   // a stalled issue leaves the scoreboard alone.
   always_comb begin
      busy_d = busy_q;
      if (i_clr_en) busy_d[i_clr_rd] = 1'b0;
      if (i_issue_en && (i_issue_rd != '0) && !hazard) busy_d[i_issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Busy register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) busy_q <= '0;
      else          busy_q <= busy_d;
   end

   assign o_busy = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: arbitrates ALU and LSU results onto the single
// register file write port (LSU priority with ALU anti-starvation) and
// tracks pending destinations through the scoreboard.
module rf_wb_scheduler
   import rf_wb_scheduler_pkg::*;
#(
   parameter int STARVE_LIMIT = 3
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   rf_wb_scheduler_if.slave    wb,
   input  logic                i_issue_en,
   input  reg_idx_t            i_issue_rd,
   input  reg_idx_t            i_rs1,
   input  reg_idx_t            i_rs2,
   output logic                o_stall,
   output logic [NUM_REGS-1:0] o_busy
);

   localparam int               CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   grant_e           grant;
   reg_idx_t         wnum;
   logic [CNT_W-1:0] starv_d, starv_q;

   // Arbitration: LSU first unless the ALU has lost STARVE_LIMIT times in a row;
   // reset kills any grant immediately.
   always_comb begin
      grant = GNT_NONE;
      if (i_rst_n) begin
         if (wb.i_lsu_valid && !(wb.i_alu_valid && (starv_q == STARVE_MAX))) grant = GNT_LSU;
         else if (wb.i_alu_valid)                                             grant = GNT_ALU;
      end
   end

   // Write port and ready outputs, combinational from the grant; x0 writes are
   // accepted but never reach the register file.
   always_comb begin
      wb.o_alu_ready = (grant == GNT_ALU);
      wb.o_lsu_ready = (grant == GNT_LSU);
      wnum           = '0;
      wb.o_Wd        = '0;
      unique case (grant)
         GNT_ALU: begin
            wnum    = wb.i_alu_rd;
            wb.o_Wd = wb.i_alu_wd;
         end
         GNT_LSU: begin
            wnum    = wb.i_lsu_rd;
            wb.o_Wd = wb.i_lsu_wd;
         end
         default: ;
      endcase
      wb.o_Wnum = wnum;
      wb.o_Wen  = (grant != GNT_NONE) && (wnum != '0);
   end

   // Starvation count: consecutive cycles the ALU waited, saturating.
   always_comb begin
      starv_d = '0;
      if (wb.i_alu_valid && (grant != GNT_ALU))
         starv_d = (starv_q == STARVE_MAX) ? starv_q : starv_q + CNT_W'(1);
   end

   // Starvation counter register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) starv_q <= '0;
      else          starv_q <= starv_d;
   end

   rf_scoreboard u_scoreboard (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_issue_en (i_issue_en),
      .i_issue_rd (i_issue_rd),
      .i_rs1      (i_rs1),
      .i_rs2      (i_rs2),
      .i_clr_en   (wb.o_Wen),
      .i_clr_rd   (wb.o_Wnum),
      .o_stall    (o_stall),
      .o_busy     (o_busy)
   );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_rf_wb_scheduler;
   import rf_wb_scheduler_pkg::*;

   localparam int LIMIT = 3;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                issue_en;
   reg_idx_t            issue_rd, rs1, rs2;
   logic                stall;
   logic [NUM_REGS-1:0] busy;

   rf_wb_scheduler_if bus ();

   rf_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .wb         (bus),
      .i_issue_en (issue_en),
      .i_issue_rd (issue_rd),
      .i_rs1      (rs1),
      .i_rs2      (rs2),
      .o_stall    (stall),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int          m_starve;
   logic [31:0] m_busy;

   // values observed at the last checked negedge
   int   obs_gnt;
   logic obs_stall;
   logic obs_wen;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      bus.i_alu_valid = 1'b0; bus.i_alu_rd = '0; bus.i_alu_wd = '0;
      bus.i_lsu_valid = 1'b0; bus.i_lsu_rd = '0; bus.i_lsu_wd = '0;
      issue_en = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
   endtask

   // One clock with inputs already applied: check combinational outputs
   // mid-cycle, advance the model, check the scoreboard after the edge.
   task automatic run_cycle();
      int          gnt;
      logic        wen, stl;
      logic [4:0]  wnum;
      logic [31:0] wd;
      @(negedge clk);
      if (bus.i_alu_valid && bus.i_lsu_valid) gnt = (m_starve == LIMIT) ? 1 : 2;
      else if (bus.i_lsu_valid)               gnt = 2;
      else if (bus.i_alu_valid)               gnt = 1;
      else                                    gnt = 0;
      wnum = (gnt == 1) ? bus.i_alu_rd : (gnt == 2) ? bus.i_lsu_rd : 5'd0;
      wd   = (gnt == 1) ? bus.i_alu_wd : (gnt == 2) ? bus.i_lsu_wd : 32'd0;
      wen  = (gnt != 0) && (wnum != 0);
      stl  = ((rs1 != 0) && m_busy[rs1]) || ((rs2 != 0) && m_busy[rs2]) ||
             (issue_en && (issue_rd != 0) && m_busy[issue_rd]);

      obs_gnt   = bus.o_alu_ready ? (bus.o_lsu_ready ? 3 : 1) : (bus.o_lsu_ready ? 2 : 0);
      obs_stall = stall;
      obs_wen   = bus.o_Wen;
      chk("grant", obs_gnt, gnt);
      chk("wen", bus.o_Wen, wen);
      chk("wnum", bus.o_Wnum, wnum);
      if (wen || gnt == 0) chk("wd", bus.o_Wd, wd);
      chk("stall", stall, stl);

      if (bus.i_alu_valid && gnt != 1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                             m_starve = 0;
      if (wen) m_busy[wnum] = 1'b0;
      if (issue_en && issue_rd != 0 && !stl) m_busy[issue_rd] = 1'b1;

      @(posedge clk); #1;
      chk("busy", busy, m_busy);
   endtask

   int exp_seq [6] = '{2, 2, 2, 1, 2, 2};

   initial begin
      // reset with requests and an issue pending: everything must stay quiet
      set_idle();
      bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd1;
      bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd2;
      issue_en = 1'b1; issue_rd = 5'd3;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 32'd0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_alu_ready", bus.o_alu_ready, 1'b0);
      chk("rst_lsu_ready", bus.o_lsu_ready, 1'b0);
      chk("rst_wen", bus.o_Wen, 1'b0);
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      m_starve = 0;
      m_busy   = '0;
      chk("post_rst_busy", busy, 32'd0);

      // both requesters valid for six cycles
      bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd10; bus.i_alu_wd = 32'h1111_0000;
      bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd11; bus.i_lsu_wd = 32'h2222_0000;
      for (int i = 0; i < 6; i++) begin
         run_cycle();
         chk("arb_seq", obs_gnt, exp_seq[i]);
      end
      set_idle();
      run_cycle();

      // RAW hazard on x5 resolved by an LSU write in cycle 3
      issue_en = 1'b1; issue_rd = 5'd5;
      run_cycle();
      chk("raw_c0_stall", obs_stall, 1'b0);
      issue_en = 1'b0; issue_rd = '0; rs1 = 5'd5;
      run_cycle();
      chk("raw_c1_stall", obs_stall, 1'b1);
      run_cycle();
      chk("raw_c2_stall", obs_stall, 1'b1);
      bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd5; bus.i_lsu_wd = 32'hCAFE_0005;
      run_cycle();
      chk("raw_c3_stall", obs_stall, 1'b1);
      chk("raw_x5_cleared", busy[5], 1'b0);
      bus.i_lsu_valid = 1'b0;
      run_cycle();
      chk("raw_c4_stall", obs_stall, 1'b0);
      set_idle();

      // ALU write to x0 is accepted but never written
      issue_en = 1'b1; issue_rd = 5'd12;
      run_cycle();
      issue_en = 1'b0; issue_rd = '0;
      bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd0; bus.i_alu_wd = 32'hDEAD_BEEF;
      run_cycle();
      chk("x0_ready", obs_gnt, 1);
      chk("x0_wen", obs_wen, 1'b0);
      chk("x0_busy", busy, 32'h0000_1000);
      set_idle();

      // issue and writeback on the same register: set wins
      issue_en = 1'b1; issue_rd = 5'd7;
      bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd7; bus.i_lsu_wd = 32'h0000_0777;
      run_cycle();
      chk("set_wins_x7", busy[7], 1'b1);
      set_idle();

      // WAW issue while the destination is pending stalls and changes nothing
      issue_en = 1'b1; issue_rd = 5'd4;
      run_cycle();
      run_cycle();
      chk("waw_stall", obs_stall, 1'b1);
      chk("waw_busy", busy, 32'h0000_1090);
      set_idle();

      // asynchronous reset pulse between edges during arbitration
      issue_en = 1'b1; issue_rd = 5'd3;
      run_cycle();
      issue_rd = 5'd9;
      run_cycle();
      bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd6; bus.i_alu_wd = 32'h0000_0006;
      bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd8; bus.i_lsu_wd = 32'h0000_0008;
      issue_rd = 5'd3; rs1 = 5'd9;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 32'd0);
      chk("arst_stall", stall, 1'b0);
      chk("arst_alu_ready", bus.o_alu_ready, 1'b0);
      chk("arst_lsu_ready", bus.o_lsu_ready, 1'b0);
      chk("arst_wen", bus.o_Wen, 1'b0);
      set_idle();
      #1;
      rst_n = 1'b1;
      m_busy   = '0;
      m_starve = 0;
      @(posedge clk); #1;
      chk("arst_after_busy", busy, 32'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         bus.i_alu_valid = ($urandom_range(0, 9) < 6);
         bus.i_alu_rd    = 5'($urandom_range(0, 15));
         bus.i_alu_wd    = $urandom();
         bus.i_lsu_valid = ($urandom_range(0, 9) < 5);
         bus.i_lsu_rd    = 5'($urandom_range(0, 15));
         bus.i_lsu_wd    = $urandom();
         issue_en        = ($urandom_range(0, 9) < 4);
         issue_rd        = 5'($urandom_range(0, 15));
         rs1             = 5'($urandom_range(0, 15));
         rs2             = 5'($urandom_range(0, 15));
         run_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete by %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
